tero_meas_ctrl: RTL and testbench
=================================

// Module: tero_meas_ctrl
// PURPOSE
// Parametrised excitation/measurement controller for an array of N_CH TERO PUF cells.
// - Drives each cell's enable_1/enable_2 pair through one timed excitation.
// - Counts the transient oscillations seen on each cell's dout_1 and latches per-channel
//   counts, saturation flags and one response bit per channel.
// - Sits between the PUF top-level sequencer (start/done) and the instantiated TERO cells.
// PARAMETERS
// N_CH         4     number of TERO channels
// CNT_W        8     oscillation counter width per channel (>=2)
// WIN_CYCLES   1024  clk cycles enables are held high (counting window), >=1
// RELAX_CYCLES 16    clk cycles enables are held low after window (cell discharge), >=1
// PORTS
// clk        in   1           system clock, all logic rising-edge
// rst_n      in   1           asynchronous active-low reset
// start      in   1           request one measurement; sampled only in IDLE
// busy       out  1           high from CLEAR through DONE inclusive
// done       out  1           one-cycle pulse, results valid from this cycle
// tero_en_1  out  N_CH        enable_1 of each cell
// tero_en_2  out  N_CH        enable_2 of each cell
// tero_out   in   N_CH        dout_1 of each cell (asynchronous to clk)
// counts     out  N_CH*CNT_W  latched counts, channel i at [i*CNT_W +: CNT_W]
// sat        out  N_CH        channel counter reached all-ones during window
// response   out  N_CH        response bit = counts[i*CNT_W] (count LSB)
// BEHAVIOUR
// - Reset: FSM=IDLE, tero_en_1/2=0, busy=0, done=0, counts=0, sat=0, response=0, internal
//   counters/syncs=0. Reset asserted mid-measurement aborts immediately: enables drop
//   asynchronously, no done.
// - tero_out[i] passes a 2-flop synchroniser, then a registered previous-value flop; a
//   rising edge = sync=1 & prev=0.
// - FSM states and durations:
//   IDLE  : enables 0; start=1 -> CLEAR.
//   CLEAR : 1 cycle; working counters and sat cleared, enables 0 -> EXCITE.
//   EXCITE: WIN_CYCLES cycles; tero_en_1=tero_en_2=all ones; each detected rising edge
//           increments its channel counter; counter saturates at 2^CNT_W-1 (no wrap),
//           sets working sat bit -> RELAX.
//   RELAX : RELAX_CYCLES cycles; enables 0; edges still counted for first 2 cycles only
//           (sync pipeline drain), ignored afterwards -> DONE.
//   DONE  : 1 cycle; done=1; counts/sat/response registered from working values (visible
//           in the same cycle via registered update on entry) -> IDLE.
// - Timing: start high at edge T (in IDLE) -> busy=1 from T+1, enables high T+2 ..
//   T+1+WIN_CYCLES, done=1 at cycle T+2+WIN_CYCLES+RELAX_CYCLES, busy=0 next cycle.
// - start while busy is ignored (no queueing). start held high continuously -> back-to-back
//   measurements, one IDLE cycle between DONE and next CLEAR.
// - Latched outputs hold until the next DONE; a new measurement does not clear them
//   before DONE.
// - Window/relax counter width = $clog2(max(WIN_CYCLES,RELAX_CYCLES)+1).
// - All channels share one window: enables of all channels toggle on the same edge.
// TESTING
// 1 Reset: rst_n=0 with tero_out toggling -> all outputs 0, enables 0, busy 0.
// 2 Nominal (N_CH=4, WIN=64, RELAX=16): cell i toggles 3+i times during window ->
//   counts={6,5,4,3} (ch3..ch0), response=4'b0101, sat=0, done at T+82.
// 3 Saturation (CNT_W=4): ch0 toggles 40 times -> counts ch0=15, sat[0]=1,
//   other channels unaffected.
// 4 Edges after RELAX cycle 2 and start pulses while busy -> not counted/ignored;
//   exactly one done pulse.
// 5 Mid-window rst_n=0 for 1 cycle -> enables drop same cycle, no done, outputs 0;
//   next start gives clean result.
// 6 start held high 3 measurements -> done every WIN+RELAX+3 cycles; counts reflect each
//   run, no accumulation.

Source files
------------

// File: rtl/tero_meas_ctrl.sv
// tero_meas_ctrl -- excitation/measurement controller for N_CH TERO PUF cells.
//
// Runs one timed excitation per start request. All cells are enabled together
// for WIN_CYCLES, then held low for RELAX_CYCLES. Rising edges on each cell's
// dout_1 are counted per channel, and the results are latched on DONE.
//
// Ports
//   clk, rst_n        system clock / async active-low reset
//   start             measurement request, sampled only in IDLE
//   busy              high from CLEAR through DONE
//   done              one-cycle pulse; results valid from this cycle
//   tero_en_1/2       enable pair of each cell (all channels share one window)
//   tero_out          dout_1 of each cell, asynchronous to clk
//   counts            latched counts, channel i at [i*CNT_W +: CNT_W]
//   sat               channel counter reached all-ones
//   response          count LSB per channel

// Per-channel lane: synchroniser, edge detect, saturating counter, result latch.
module tero_meas_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tero_out,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             latch,
  output logic [CNT_W-1:0] cnt_q,
  output logic             sat_q
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1, sync2, prev, rise;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sat_w, sat_d;

  assign rise = sync2 & ~prev;

  always_comb begin
    cnt_d = cnt;
    sat_d = sat_w;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (cnt_en && rise && (cnt != CNT_MAX)) begin
      cnt_d = cnt + 1'b1;
      if (cnt_d == CNT_MAX) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
      sat_w <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sync1 <= tero_out;
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_d;
      sat_w <= sat_d;
      // Latch the next-state value so an edge counted on the final RELAX
      // cycle is not lost when RELAX_CYCLES is very short.
      if (latch) begin
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
    end
  end
endmodule

module tero_meas_ctrl #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 8,
  parameter int WIN_CYCLES   = 1024,
  parameter int RELAX_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH-1:0]       tero_en_1,
  output logic [N_CH-1:0]       tero_en_2,
  input  logic [N_CH-1:0]       tero_out,
  output logic [N_CH*CNT_W-1:0] counts,
  output logic [N_CH-1:0]       sat,
  output logic [N_CH-1:0]       response
);
  localparam int TMAX = (WIN_CYCLES > RELAX_CYCLES) ? WIN_CYCLES : RELAX_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, EXCITE, RELAX, DONE} state_t;

  state_t        state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [TW:0]   tmr_x;
  logic          en_q, busy_q, done_q;
  logic          clr, cnt_en, latch, drain;

  logic [N_CH-1:0][CNT_W-1:0] cnt_arr;

  // Widened copy so the "< 2" compare stays legal even when TW is 1.
  assign tmr_x = {1'b0, tmr};
  assign drain = (tmr_x < (TW+1)'(2));

  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    case (state)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = EXCITE;
        tmr_d   = '0;
      end
      EXCITE: begin
        if (tmr == TW'(WIN_CYCLES - 1)) begin
          state_d = RELAX;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      RELAX: begin
        if (tmr == TW'(RELAX_CYCLES - 1)) begin
          state_d = DONE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first two RELAX cycles still count edges that were in flight in
  // the synchroniser when the enables dropped.
  assign clr    = (state == CLEAR);
  assign cnt_en = (state == EXCITE) || ((state == RELAX) && drain);
  assign latch  = (state == RELAX) && (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      tmr    <= tmr_d;
      // Registered from next state: glitch-free enables and status,
      // aligned exactly with the state they describe.
      en_q   <= (state_d == EXCITE);
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign tero_en_1 = {N_CH{en_q}};
  assign tero_en_2 = {N_CH{en_q}};
  assign busy      = busy_q;
  assign done      = done_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    tero_meas_lane #(.CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .tero_out (tero_out[i]),
      .clr      (clr),
      .cnt_en   (cnt_en),
      .latch    (latch),
      .cnt_q    (cnt_arr[i]),
      .sat_q    (sat[i])
    );
    assign response[i] = cnt_arr[i][0];
  end

  assign counts = cnt_arr;
endmodule

// File: tb/tb_tero_meas_ctrl.sv
module tb_tero_meas_ctrl;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 4;
  localparam int WIN    = 64;
  localparam int RELAX  = 16;
  localparam int DONE_C = WIN + RELAX + 2;  // done cycle, relative to the start edge
  localparam int LEN    = WIN + RELAX + 3;  // measurement period incl. one IDLE cycle
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int LATE0  = WIN + 6;          // first late edge, well past the drain cycles

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [N_CH-1:0]       tero_out = '0;
  logic                  busy, done;
  logic [N_CH-1:0]       tero_en_1, tero_en_2, sat, response;
  logic [N_CH*CNT_W-1:0] counts;

  tero_meas_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WIN_CYCLES(WIN), .RELAX_CYCLES(RELAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tero_en_1(tero_en_1), .tero_en_2(tero_en_2), .tero_out(tero_out),
    .counts(counts), .sat(sat), .response(response)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus per channel: np window pulses starting at cycle ofs, nl late pulses.
  int np[N_CH];
  int nl[N_CH];
  int ofs[N_CH];

  // Reference results currently expected on the latched outputs.
  logic [N_CH*CNT_W-1:0] exp_counts = '0;
  logic [N_CH-1:0]       exp_sat = '0;
  logic [N_CH-1:0]       exp_resp = '0;

  // Pulse pattern of a channel in cycle c after the start edge.
  function automatic logic pat(input int ch, input int c);
    int d = c - ofs[ch];
    int l = c - LATE0;
    return ((d >= 0) && (d % 2 == 0) && (d / 2 < np[ch])) ||
           ((l >= 0) && (l % 2 == 0) && (l / 2 < nl[ch]));
  endfunction

  // One measurement. Entered at a negedge; starts it by raising start now.
  task automatic run_meas(input string name, input bit noise, input bit keep);
    logic [N_CH*CNT_W-1:0]     new_counts;
    logic [N_CH-1:0]           new_sat, new_resp, e;
    logic [2*N_CH+1:0]         ctl_exp, ctl_obs;
    logic [N_CH*(CNT_W+2)-1:0] res_exp, res_obs;
    int ndone = 0;
    // Model: every window pulse counts, late ones never; counter clamps at all-ones.
    for (int ch = 0; ch < N_CH; ch++) begin
      int cv = (np[ch] > CMAX) ? CMAX : np[ch];
      new_counts[ch*CNT_W +: CNT_W] = CNT_W'(cv);
      new_sat[ch]  = (np[ch] >= CMAX);
      new_resp[ch] = (cv % 2 == 1);
    end
    start    = 1'b1;
    tero_out = '0;
    for (int c = 1; c <= LEN; c++) begin
      @(negedge clk);
      e       = (c >= 2 && c <= WIN + 1) ? {N_CH{1'b1}} : '0;
      ctl_exp = {(c >= 1 && c <= DONE_C), (c == DONE_C), e, e};
      ctl_obs = {busy, done, tero_en_1, tero_en_2};
      n_chk++;
      if (ctl_obs !== ctl_exp) begin
        if (n_chk - n_pass < 30)
          $display("FAIL %s ctrl c=%0d busy/done/en1/en2 got %b want %b", name, c, ctl_obs, ctl_exp);
      end else n_pass++;
      res_exp = (c >= DONE_C) ? {new_counts, new_sat, new_resp} : {exp_counts, exp_sat, exp_resp};
      res_obs = {counts, sat, response};
      n_chk++;
      if (res_obs !== res_exp) begin
        if (n_chk - n_pass < 30)
          $display("FAIL %s result c=%0d counts/sat/resp got %h want %h", name, c, res_obs, res_exp);
      end else n_pass++;
      if (done === 1'b1) ndone++;
      if (c == LEN) begin
        start    = keep;
        tero_out = '0;
      end else begin
        if (keep) start = 1'b1;
        else if (noise && c >= 2 && c <= DONE_C - 4) start = 1'($urandom_range(0, 1));
        else start = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) tero_out[ch] = pat(ch, c);
      end
    end
    n_chk++;
    if (ndone !== 1) $display("FAIL %s done_pulses got %0d want 1", name, ndone);
    else n_pass++;
    exp_counts = new_counts;
    exp_sat    = new_sat;
    exp_resp   = new_resp;
  endtask

  task automatic test_reset;
    logic [4*N_CH+N_CH*CNT_W+1:0] obs;
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tero_out = N_CH'($urandom);
      start    = 1'($urandom_range(0, 1));
      obs = {busy, done, tero_en_1, tero_en_2, counts, sat, response};
      n_chk++;
      if (obs !== '0) $display("FAIL reset_outputs k=%0d got %h want 0", k, obs);
      else n_pass++;
    end
    @(negedge clk);
    tero_out = '0;
    start    = 1'b0;
    rst_n    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if ({busy, done, tero_en_1} !== '0) $display("FAIL reset_idle got %b want 0", {busy, done, tero_en_1});
      else n_pass++;
    end
  endtask

  task automatic test_nominal;
    np  = '{3, 4, 5, 6};
    nl  = '{0, 0, 0, 0};
    ofs = '{4, 4, 4, 4};
    run_meas("nominal", 1'b0, 1'b0);
    n_chk++;
    if ({counts, response, sat} !== {16'h6543, 4'b0101, 4'b0000})
      $display("FAIL nominal_const got %h/%b/%b want 6543/0101/0000", counts, response, sat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    // ch0 far past all-ones, ch2 one below, ch3 exactly at all-ones.
    np  = '{29, 2, 14, 15};
    nl  = '{0, 0, 0, 0};
    ofs = '{4, 5, 4, 5};
    run_meas("saturation", 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_late_edges;
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        np[ch]  = $urandom_range(0, 29);
        nl[ch]  = $urandom_range(1, 4);
        ofs[ch] = $urandom_range(4, 5);
      end
      run_meas("late_edges", 1'b1, 1'b0);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_abort;
    logic [4*N_CH+N_CH*CNT_W+1:0] obs;
    np  = '{9, 10, 11, 12};
    nl  = '{0, 0, 0, 0};
    ofs = '{4, 4, 4, 4};
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) tero_out[ch] = pat(ch, c);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {busy, done, tero_en_1, tero_en_2, counts, sat, response};
    n_chk++;
    if (obs !== '0) $display("FAIL abort_async got %h want 0", obs);
    else n_pass++;
    @(negedge clk);
    tero_out = '0;
    rst_n    = 1'b1;
    exp_counts = '0;
    exp_sat    = '0;
    exp_resp   = '0;
    for (int k = 0; k < LEN + 5; k++) begin
      @(negedge clk);
      obs = {busy, done, tero_en_1, tero_en_2, counts, sat, response};
      n_chk++;
      if (obs !== '0) $display("FAIL abort_quiet k=%0d got %h want 0", k, obs);
      else n_pass++;
    end
    np  = '{1, 8, 0, 13};
    ofs = '{5, 4, 5, 4};
    run_meas("post_abort", 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        np[ch]  = $urandom_range(0, 20);
        nl[ch]  = $urandom_range(0, 4);
        ofs[ch] = $urandom_range(4, 5);
      end
      run_meas("back_to_back", 1'b0, (r < 2));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_late_edges();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
